// File: rtl/wb_lsu_master.sv
// wb_lsu_master
// Wishbone classic master that turns CPU load/store requests into single bus
// cycles for the flash/RAM slaves.
// For stores it builds byte enables and copies the write data onto every lane.
// For loads it picks the addressed lane out of the returned word and extends it.
// Misaligned requests, illegal sizes and bus timeouts come back as errors.
//
// Ports
//   CLK_I, RST_I              clock (rising edge), async active-low reset
//   req_valid / req_ready     CPU request handshake (ready only while idle)
//   req_we, req_addr, req_wdata, req_size, req_unsigned   request fields
//   resp_valid, resp_rdata, resp_err                      one-cycle response
//   CYC_O, STB_O, ADR_O, DAT_O, SEL_O, WE_O               Wishbone master outputs
//   ACK_I, DAT_I                                          Wishbone slave inputs
module wb_lsu_master #(
   parameter int ADDR_WIDTH     = 27,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK_I,
   input  logic                  RST_I,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [31:0]           req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic                  CYC_O,
   output logic                  STB_O,
   output logic [ADDR_WIDTH-1:0] ADR_O,
   output logic [31:0]           DAT_O,
   output logic [3:0]            SEL_O,
   output logic                  WE_O,
   input  logic                  ACK_I,
   input  logic [31:0]           DAT_I
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUS  = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   logic [1:0]       state;
   logic [CNT_W-1:0] timeout_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [1:0]       lat_size;
   logic [1:0]       lat_lane;
   logic             lat_unsigned;
   logic             lat_we;
   logic             bad_request;
   logic [3:0]       sel_next;
   logic [31:0]      wdata_next;
   logic [7:0]       load_byte;
   logic [15:0]      load_half;
   logic [31:0]      load_data;

   assign req_ready = (state == IDLE);
   assign cnt_next  = timeout_cnt + 1'b1;

   // Address bits above the bus width are not decoded by the slaves.
   generate
      if (ADDR_WIDTH < 32) begin : g_unused_addr
         logic unused_addr_bits;
         assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH];
      end
   endgenerate

   // Requests that cannot become a legal single bus cycle go straight to an error response.
   always_comb begin
      bad_request = 1'b0;
      case (req_size)
         2'd1:    bad_request = req_addr[0];
         2'd2:    bad_request = (req_addr[1:0] != 2'b00);
         2'd3:    bad_request = 1'b1;
         default: bad_request = 1'b0;
      endcase
   end

   // Byte enables and lane-replicated write data for the incoming request.
   always_comb begin
      sel_next   = 4'b1111;
      wdata_next = req_wdata;
      case (req_size)
         2'd0: begin
            sel_next   = 4'b0001 << req_addr[1:0];
            wdata_next = {4{req_wdata[7:0]}};
         end
         2'd1: begin
            sel_next   = req_addr[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{req_wdata[15:0]}};
         end
         default: begin
            sel_next   = 4'b1111;
            wdata_next = req_wdata;
         end
      endcase
   end

   // The slaves always return a full word, so pick out the addressed lane and extend it here.
   always_comb begin
      load_byte = DAT_I[8*lat_lane +: 8];
      load_half = DAT_I[16*lat_lane[1] +: 16];
      load_data = DAT_I;
      case (lat_size)
         2'd0:    load_data = lat_unsigned ? {24'b0, load_byte} : {{24{load_byte[7]}}, load_byte};
         2'd1:    load_data = lat_unsigned ? {16'b0, load_half} : {{16{load_half[15]}}, load_half};
         default: load_data = DAT_I;
      endcase
   end

   // Main control: accept in IDLE, run one bus cycle in BUS, pulse the response in RESP.
   // ACK_I is only looked at in BUS, so the slave's trailing ACK during RESP is harmless.
   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state        <= IDLE;
         timeout_cnt  <= '0;
         lat_size     <= 2'd0;
         lat_lane     <= 2'd0;
         lat_unsigned <= 1'b0;
         lat_we       <= 1'b0;
         CYC_O        <= 1'b0;
         STB_O        <= 1'b0;
         WE_O         <= 1'b0;
         SEL_O        <= 4'b0;
         ADR_O        <= '0;
         DAT_O        <= 32'b0;
         resp_valid   <= 1'b0;
         resp_err     <= 1'b0;
         resp_rdata   <= 32'b0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_size     <= req_size;
                  lat_lane     <= req_addr[1:0];
                  lat_unsigned <= req_unsigned;
                  lat_we       <= req_we;
                  if (bad_request) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'b0;
                  end else begin
                     state       <= BUS;
                     CYC_O       <= 1'b1;
                     STB_O       <= 1'b1;
                     WE_O        <= req_we;
                     SEL_O       <= sel_next;
                     DAT_O       <= wdata_next;
                     ADR_O       <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     timeout_cnt <= '0;
                  end
               end
            end
            BUS: begin
               if (ACK_I) begin
                  state      <= RESP;
                  CYC_O      <= 1'b0;
                  STB_O      <= 1'b0;
                  WE_O       <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= lat_we ? 32'b0 : load_data;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_next == CNT_W'(TIMEOUT_CYCLES))) begin
                  state      <= RESP;
                  CYC_O      <= 1'b0;
                  STB_O      <= 1'b0;
                  WE_O       <= 1'b0;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= 32'b0;
               end else begin
                  timeout_cnt <= cnt_next;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_lsu_master.sv
// tb_wb_lsu_master
// Directed bench for wb_lsu_master. A one-cycle slave model answers bus cycles,
// expected bus transactions and responses are queued when a request is issued,
// and a monitor pops and compares them whenever the DUT shows a bus cycle or a
// response.
module tb_wb_lsu_master;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'b0;
   logic [31:0] req_wdata = 32'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        CYC_O;
   logic        STB_O;
   logic [26:0] ADR_O;
   logic [31:0] DAT_O;
   logic [3:0]  SEL_O;
   logic        WE_O;
   logic        ACK_I;
   logic [31:0] DAT_I;

   logic        ack_en = 1'b1;
   logic [31:0] slave_word = 32'b0;
   int          cycle = 0;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          at;
   } resp_t;

   typedef struct {
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        we;
      int          len;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];

   wb_lsu_master #(
      .ADDR_WIDTH(27),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .CLK_I(CLK_I),
      .RST_I(RST_I),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we(req_we),
      .req_addr(req_addr),
      .req_wdata(req_wdata),
      .req_size(req_size),
      .req_unsigned(req_unsigned),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .CYC_O(CYC_O),
      .STB_O(STB_O),
      .ADR_O(ADR_O),
      .DAT_O(DAT_O),
      .SEL_O(SEL_O),
      .WE_O(WE_O),
      .ACK_I(ACK_I),
      .DAT_I(DAT_I)
   );

   always #5 CLK_I = ~CLK_I;

   // Cycle counter used to check response latency.
   always @(posedge CLK_I) cycle <= cycle + 1;

   // Slave model: ACK registered from STB, so it also produces the trailing stray ACK.
   always @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) ACK_I <= 1'b0;
      else        ACK_I <= CYC_O && STB_O && ack_en;
   end

   assign DAT_I = slave_word;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares each new bus cycle and each response against the queued expectations.
   bus_t cur_bus = '{32'b0, 4'b0, 32'b0, 1'b0, 0};
   int   cyc_len = 0;
   logic cyc_prev = 1'b0;
   always @(negedge CLK_I) begin
      if (!RST_I) begin
         cyc_len  = 0;
         cyc_prev = 1'b0;
      end else begin
         if (CYC_O && !cyc_prev) begin
            if (bus_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_bus_cycle: got CYC_O=1 expected 0");
               cur_bus.len = 0;
            end else begin
               cur_bus = bus_q.pop_front();
               checkOutput("adr", {5'b0, ADR_O}, cur_bus.adr);
               checkOutput("sel", {28'b0, SEL_O}, {28'b0, cur_bus.sel});
               checkOutput("we", {31'b0, WE_O}, {31'b0, cur_bus.we});
               checkOutput("stb", {31'b0, STB_O}, 32'd1);
               if (cur_bus.we) checkOutput("dat", DAT_O, cur_bus.dat);
            end
            cyc_len = 1;
         end else if (CYC_O) begin
            cyc_len++;
         end else if (cyc_prev && cur_bus.len != 0) begin
            checkOutput("cyc_len", cyc_len, cur_bus.len);
         end
         cyc_prev = CYC_O;

         if (resp_valid) begin
            if (resp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected 0");
            end else begin
               resp_t r;
               r = resp_q.pop_front();
               checkOutput("resp_rdata", resp_rdata, r.rdata);
               checkOutput("resp_err", {31'b0, resp_err}, {31'b0, r.err});
               checkOutput("resp_cycle", cycle, r.at);
               checkOutput("ready_in_resp", {31'b0, req_ready}, 32'd0);
            end
         end
      end
   end

   // Issues one request and queues the bus cycle / response it should produce.
   task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input logic issue,
                                input logic [3:0] esel, input logic [31:0] edat,
                                input logic [31:0] erdata, input logic eerr, input int lat,
                                input int len, input logic expect_resp);
      int waited = 0;
      @(negedge CLK_I);
      while (!req_ready && waited < 20) begin
         @(negedge CLK_I);
         waited++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL ready_wait: got req_ready=0 expected 1 within 20 cycles");
      end
      req_we       = we;
      req_addr     = addr;
      req_wdata    = wdata;
      req_size     = size;
      req_unsigned = uns;
      req_valid    = 1'b1;
      if (issue) bus_q.push_back('{addr & 32'hFFFF_FFFC, esel, edat, we, len});
      if (expect_resp) resp_q.push_back('{erdata, eerr, cycle + lat});
      @(posedge CLK_I);
      #1;
      req_valid    = 1'b0;
      req_addr     = 32'hFFFF_FFFF;
      req_size     = 2'd3;
      req_wdata    = 32'h0BAD_0BAD;
      req_unsigned = ~uns;
      req_we       = ~we;
   endtask

   // Watchdog so a stuck DUT can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence.
   initial begin
      $display("[TB] starting wb_lsu_master bench");
      #12;
      checkOutput("rst_cyc", {31'b0, CYC_O}, 32'd0);
      checkOutput("rst_stb", {31'b0, STB_O}, 32'd0);
      checkOutput("rst_we", {31'b0, WE_O}, 32'd0);
      checkOutput("rst_sel", {28'b0, SEL_O}, 32'd0);
      checkOutput("rst_adr", {5'b0, ADR_O}, 32'd0);
      checkOutput("rst_dat", DAT_O, 32'd0);
      checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
      checkOutput("rst_ready", {31'b0, req_ready}, 32'd1);
      @(negedge CLK_I);
      RST_I = 1'b1;

      // Word load, then stores and lane-extracted loads.
      slave_word = 32'hDEADBEEF;
      applyStimulus(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b1, 32'h103, 32'h0000005A, 2'd0, 1'b0, 1'b1, 4'b1000, 32'h5A5A5A5A, 32'h0, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b1, 32'h002, 32'h1234ABCD, 2'd1, 1'b0, 1'b1, 4'b1100, 32'hABCDABCD, 32'h0, 1'b0, 3, 2, 1'b1);
      slave_word = 32'h80017FFF;
      applyStimulus(1'b0, 32'h102, 32'h0, 2'd1, 1'b0, 1'b1, 4'b1100, 32'h0, 32'hFFFF8001, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b0, 32'h102, 32'h0, 2'd1, 1'b1, 1'b1, 4'b1100, 32'h0, 32'h00008001, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b0, 32'h101, 32'h0, 2'd0, 1'b0, 1'b1, 4'b0010, 32'h0, 32'h0000007F, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b0, 32'h100, 32'h0, 2'd0, 1'b0, 1'b1, 4'b0001, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b0, 32'h100, 32'h0, 2'd0, 1'b1, 1'b1, 4'b0001, 32'h0, 32'h000000FF, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b0, 32'h000, 32'h0, 2'd1, 1'b0, 1'b1, 4'b0011, 32'h0, 32'h00007FFF, 1'b0, 3, 2, 1'b1);

      // Misaligned and illegal requests: no bus cycle, error after one cycle.
      applyStimulus(1'b1, 32'h102, 32'h11111111, 2'd2, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0, 1'b1);
      applyStimulus(1'b0, 32'h001, 32'h0, 2'd1, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0, 1'b1);
      applyStimulus(1'b0, 32'h200, 32'h0, 2'd3, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 1, 0, 1'b1);

      // Timeout with a silent slave, then a normal access afterwards.
      repeat (4) @(negedge CLK_I);
      ack_en = 1'b0;
      applyStimulus(1'b0, 32'h040, 32'h0, 2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b1, 5, 4, 1'b1);
      repeat (8) @(negedge CLK_I);
      ack_en = 1'b1;
      slave_word = 32'hCAFEF00D;
      applyStimulus(1'b0, 32'h104, 32'h0, 2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'hCAFEF00D, 1'b0, 3, 2, 1'b1);

      // Reset in the middle of a bus cycle drops the cycle at once and loses the request.
      repeat (4) @(negedge CLK_I);
      ack_en = 1'b0;
      applyStimulus(1'b0, 32'h080, 32'h0, 2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h0, 1'b0, 0, 0, 1'b0);
      @(negedge CLK_I);
      #2;
      RST_I = 1'b0;
      #1;
      checkOutput("async_rst_cyc", {31'b0, CYC_O}, 32'd0);
      checkOutput("async_rst_stb", {31'b0, STB_O}, 32'd0);
      repeat (2) @(negedge CLK_I);
      RST_I  = 1'b1;
      ack_en = 1'b1;
      @(negedge CLK_I);
      checkOutput("ready_after_rst", {31'b0, req_ready}, 32'd1);
      checkOutput("no_resp_after_rst", {31'b0, resp_valid}, 32'd0);

      slave_word = 32'h00C0FFEE;
      applyStimulus(1'b1, 32'h301, 32'h000000A5, 2'd0, 1'b0, 1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0, 1'b0, 3, 2, 1'b1);
      applyStimulus(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h00C0FFEE, 1'b0, 3, 2, 1'b1);

      repeat (10) @(negedge CLK_I);
      checkOutput("resp_queue_drained", resp_q.size(), 32'd0);
      checkOutput("bus_queue_drained", bus_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wb_lsu_master.md
Name: wb_lsu_master

Overview:
- Wishbone classic master that converts CPU load/store requests into single bus cycles; sits directly upstream of the flash/RAM slaves.
- Generates SEL_O and write-lane replication for stores.
- The slaves return whole words and ignore SEL on reads, so this block does read-lane extraction and sign/zero extension.
- Detects misaligned accesses and bus timeouts and reports them as errors.

Parameters:
ADDR_WIDTH, 27, width of ADR_O (byte address, word-aligned on the bus)
TIMEOUT_CYCLES, 255, maximum cycles to wait for ACK_I in BUS; 0 disables timeout

Ports:
CLK_I  in  1  clock, all logic on rising edge
RST_I  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size, or timeout; qualified by resp_valid
CYC_O  out  1  Wishbone cycle
STB_O  out  1  Wishbone strobe
ADR_O  out  ADDR_WIDTH  {req_addr[ADDR_WIDTH-1:2], 2'b00}
DAT_O  out  32  write data, lane-replicated
SEL_O  out  4  byte enables
WE_O  out  1  write enable
ACK_I  in  1  slave acknowledge
DAT_I  in  32  slave read word, valid when ACK_I=1

Behaviour:
- Reset (RST_I low, asynchronous): state = IDLE; CYC_O, STB_O, WE_O, resp_valid, resp_err = 0; SEL_O, ADR_O, DAT_O, resp_rdata = 0; timeout counter = 0. Reset mid-cycle drops CYC_O/STB_O immediately; the pending request is lost with no response.
- States: IDLE, BUS, RESP. All outputs are registered. req_ready = (state == IDLE).
- IDLE, on req_valid && req_ready: latch the request.
  - If size = 3, or size = 1 with addr[0] = 1, or size = 2 with addr[1:0] != 0: go to RESP with err = 1. No bus cycle is issued.
  - Otherwise: go to BUS; CYC_O = STB_O = 1, WE_O = req_we, counter cleared.
- SEL_O:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - Loads drive the same SEL_O.
- DAT_O:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- BUS: ACK_I is sampled only in this state.
  - ACK_I = 1: deassert CYC_O/STB_O on the next edge, capture the load result from DAT_I, go to RESP with err = 0.
  - No ACK: counter increments. When TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES, deassert CYC_O/STB_O and go to RESP with err = 1, rdata = 0.
- Load extraction:
  - byte: DAT_I[8*addr[1:0] +: 8]
  - half: DAT_I[16*addr[1] +: 16]
  - Extend to 32 bits per req_unsigned. Word loads pass through unchanged.
- RESP: resp_valid = 1 for exactly one cycle, then IDLE. There is no response backpressure.
- Stray ACK: the slave registers ACK from STB, so one extra ACK_I arrives in the RESP cycle. It must be ignored (no state change, no data capture). STB_O is low for at least 2 cycles between bus cycles, so the stray ACK never aliases into the next request.
- Latency against a one-cycle slave:
  - accept at cycle 0, STB_O at cycle 1, ACK_I at cycle 2, resp_valid at cycle 3, req_ready at cycle 4.
  - Error path: resp_valid at cycle 1.
- req_valid is ignored outside IDLE. Request fields are sampled only on acceptance.

Test Plan:
- Word load at 0x100, slave word 0xDEADBEEF -> STB_O cycles 1..2, SEL_O = 1111, WE_O = 0; resp_valid at cycle 3 with resp_rdata = 0xDEADBEEF, err = 0; stray ACK at cycle 3 causes no second response.
- Byte store 0x5A at 0x103 -> SEL_O = 1000, DAT_O = 0x5A5A5A5A, WE_O = 1, ADR_O = 0x100; resp_rdata = 0, err = 0.
- Half load at 0x102, slave word 0x8001_7FFF -> signed: resp_rdata = 0xFFFF8001; unsigned: 0x00008001. Byte load at 0x101, signed -> 0x0000007F.
- Word store at 0x102, half at 0x001, and size = 3 -> CYC_O never asserted; resp_valid at cycle 1 with err = 1.
- TIMEOUT_CYCLES = 4 with slave ACK tied low -> CYC_O high for 4 cycles then low; resp_err = 1, resp_rdata = 0; the next request completes normally.
- RST_I pulsed low while in BUS -> CYC_O/STB_O low immediately without a clock edge; no resp_valid; req_ready = 1 after release.
